// File: rtl/regfile_wb_stage_if.sv
// Writeback-stage bus: instruction results in from the core, register-file write port out.
// The core-side driver uses the master modport; the writeback stage uses slave.
interface regfile_wb_stage_if #(
    parameter int NUM_THREADS = 16,
    parameter int DWIDTH      = 32
);
    localparam int TW = $clog2(NUM_THREADS);

    logic [TW-1:0]     i_thread_index;
    logic [4:0]        i_rd_addr;
    logic              i_wb_en;
    logic              i_is_load;
    logic [2:0]        i_load_funct3;
    logic [1:0]        i_byte_offset;
    logic [DWIDTH-1:0] i_mem_rdata;
    logic [DWIDTH-1:0] i_alu_result;

    logic [TW-1:0]     o_rf_thread_index;
    logic [4:0]        o_rf_write_addr;
    logic [DWIDTH-1:0] o_rf_write_data;
    logic              o_rf_wr_en;
    logic              o_init_done;
    logic              o_drop_err;
    logic              o_fmt_err;

    modport master (
        output i_thread_index, i_rd_addr, i_wb_en, i_is_load, i_load_funct3,
               i_byte_offset, i_mem_rdata, i_alu_result,
        input  o_rf_thread_index, o_rf_write_addr, o_rf_write_data, o_rf_wr_en,
               o_init_done, o_drop_err, o_fmt_err
    );

    modport slave (
        input  i_thread_index, i_rd_addr, i_wb_en, i_is_load, i_load_funct3,
               i_byte_offset, i_mem_rdata, i_alu_result,
        output o_rf_thread_index, o_rf_write_addr, o_rf_write_data, o_rf_wr_en,
               o_init_done, o_drop_err, o_fmt_err
    );
endinterface

// File: rtl/regfile_wb_stage.sv
// Writeback stage for the barrel-threaded register file: load formatting, x0 suppression,
// registered write request, and a post-reset zero-fill sweep because block RAM has no reset.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into every (thread, reg) entry, writebacks dropped
// ST_RUN   | normal writeback, one-cycle registered latency
module regfile_wb_stage #(
    parameter int NUM_THREADS    = 16,
    parameter int DWIDTH         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_stage_if.slave    wb
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int CW = TW + 5;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     thread_q;
    logic [4:0]        addr_q;
    logic [DWIDTH-1:0] data_q;
    logic              wr_en_q;
    logic              init_done_q;
    logic              drop_err_q;
    logic              fmt_err_q;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              fmt_legal;
    logic [DWIDTH-1:0] fmt_data;
    logic [DWIDTH-1:0] wb_data_d;
    logic              wb_issue_d;
    logic              fmt_bad_d;

    always_comb begin
        case (wb.i_byte_offset)
            2'd0:    byte_sel = wb.i_mem_rdata[7:0];
            2'd1:    byte_sel = wb.i_mem_rdata[15:8];
            2'd2:    byte_sel = wb.i_mem_rdata[23:16];
            default: byte_sel = wb.i_mem_rdata[31:24];
        endcase
        half_sel = wb.i_byte_offset[1] ? wb.i_mem_rdata[31:16] : wb.i_mem_rdata[15:0];

        fmt_legal = 1'b1;
        fmt_data  = '0;
        case (wb.i_load_funct3)
            3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  fmt_data = {24'h0, byte_sel};
            3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  fmt_data = {16'h0, half_sel};
            3'b010:  fmt_data = wb.i_mem_rdata;
            default: fmt_legal = 1'b0;
        endcase

        wb_data_d  = wb.i_is_load ? fmt_data : wb.i_alu_result;
        // x0 is silently discarded: neither a write nor a format error
        wb_issue_d = wb.i_wb_en && (wb.i_rd_addr != 5'd0) && (!wb.i_is_load || fmt_legal);
        fmt_bad_d  = wb.i_wb_en && wb.i_is_load && !fmt_legal && (wb.i_rd_addr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q       <= '0;
            thread_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            init_done_q <= 1'b0;
            drop_err_q  <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en_q  <= 1'b1;
                    thread_q <= cnt_q[CW-1:5];
                    addr_q   <= cnt_q[4:0];
                    data_q   <= '0;
                    cnt_q    <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= ST_RUN;
                    end
                    if (wb.i_wb_en) begin
                        drop_err_q <= 1'b1;
                    end
                end
                default: begin
                    init_done_q <= 1'b1;
                    wr_en_q     <= wb_issue_d;
                    if (wb_issue_d) begin
                        thread_q <= wb.i_thread_index;
                        addr_q   <= wb.i_rd_addr;
                        data_q   <= wb_data_d;
                    end
                    if (fmt_bad_d) begin
                        fmt_err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign wb.o_rf_thread_index = thread_q;
    assign wb.o_rf_write_addr   = addr_q;
    assign wb.o_rf_write_data   = data_q;
    assign wb.o_rf_wr_en        = wr_en_q;
    assign wb.o_init_done       = init_done_q;
    assign wb.o_drop_err        = drop_err_q;
    assign wb.o_fmt_err         = fmt_err_q;
endmodule

// File: tb/tb_regfile_wb_stage.sv
// Bench for regfile_wb_stage with 4 threads: sweep, reset-restart, load formats, sticky errors,
// and randomized writebacks checked against an arithmetic reference model.
module tb_regfile_wb_stage;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    logic        m_wr;
    logic [1:0]  m_th;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_drop;
    logic        m_fmt;

    regfile_wb_stage_if #(.NUM_THREADS(4), .DWIDTH(32)) bus ();

    regfile_wb_stage #(
        .NUM_THREADS(4),
        .DWIDTH(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wb(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input logic wr, input logic [1:0] th, input logic [4:0] rd,
                                       input logic [31:0] d, input logic init, input logic drop,
                                       input logic fmt);
        return {21'h0, wr, th, rd, d, init, drop, fmt};
    endfunction

    function automatic logic [63:0] snap();
        return pk(bus.o_rf_wr_en, bus.o_rf_thread_index, bus.o_rf_write_addr, bus.o_rf_write_data,
                  bus.o_init_done, bus.o_drop_err, bus.o_fmt_err);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {legal, data}, computed by shifting the word and applying two's-complement arithmetic.
    function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int          s;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000: begin s = int'(b); if (s > 127) s -= 256; return {1'b1, 32'(s)}; end
            3'b100: return {1'b1, 32'(b)};
            3'b001: begin s = int'(h); if (s > 32767) s -= 65536; return {1'b1, 32'(s)}; end
            3'b101: return {1'b1, 32'(h)};
            3'b010: return {1'b1, w};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic idle_inputs();
        bus.i_thread_index = '0;
        bus.i_rd_addr      = '0;
        bus.i_wb_en        = 1'b0;
        bus.i_is_load      = 1'b0;
        bus.i_load_funct3  = '0;
        bus.i_byte_offset  = '0;
        bus.i_mem_rdata    = '0;
        bus.i_alu_result   = '0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        idle_inputs();
        tick();
        chk(tag, snap(), 64'h0);
        reset_n = 1'b1;
        m_wr = 0; m_th = 0; m_rd = 0; m_data = 0; m_drop = 0; m_fmt = 0;
    endtask

    task automatic sweep(input int n, input int pulse_at);
        for (int k = 1; k <= n; k++) begin
            bus.i_wb_en   = (k == pulse_at);
            bus.i_rd_addr = 5'd9;
            tick();
            if (k == pulse_at) m_drop = 1'b1;
            chk($sformatf("sweep%0d", k), snap(),
                pk(1'b1, 2'((k - 1) / 32), 5'((k - 1) % 32), 32'h0, 1'b0, m_drop, m_fmt));
        end
        idle_inputs();
        if (n == 128) begin
            tick();
            m_wr = 0; m_th = 2'd3; m_rd = 5'd31; m_data = 32'h0;
            chk("init_done", snap(), pk(1'b0, 2'd3, 5'd31, 32'h0, 1'b1, m_drop, m_fmt));
        end
    endtask

    task automatic step(input string tag, input logic [1:0] th, input logic [4:0] rd,
                        input logic en, input logic ld, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] mem, input logic [31:0] alu);
        logic [32:0] r;
        logic        legal;
        logic [31:0] d;
        bus.i_thread_index = th;
        bus.i_rd_addr      = rd;
        bus.i_wb_en        = en;
        bus.i_is_load      = ld;
        bus.i_load_funct3  = f3;
        bus.i_byte_offset  = off;
        bus.i_mem_rdata    = mem;
        bus.i_alu_result   = alu;
        r     = ref_load(f3, off, mem);
        legal = ld ? r[32] : 1'b1;
        d     = ld ? r[31:0] : alu;
        if (en && rd != 0 && legal) begin
            m_wr = 1'b1; m_th = th; m_rd = rd; m_data = d;
        end else begin
            m_wr = 1'b0;
        end
        if (en && ld && !legal && rd != 0) m_fmt = 1'b1;
        tick();
        chk(tag, snap(), pk(m_wr, m_th, m_rd, m_data, 1'b1, m_drop, m_fmt));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        idle_inputs();
        tick();

        do_reset("reset_a");
        sweep(128, 0);

        step("alu_t2r5", 2'd2, 5'd5, 1'b1, 1'b0, 3'b011, 2'd0, 32'h0, 32'hDEADBEEF);
        chk("alu_data", {32'h0, bus.o_rf_write_data}, {32'h0, 32'hDEADBEEF});
        step("alu_x0_hold", 2'd3, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h1234);
        chk("x0_hold_data", {32'h0, bus.o_rf_write_data}, {32'h0, 32'hDEADBEEF});

        step("lb_off3", 2'd1, 5'd1, 1'b1, 1'b1, 3'b000, 2'd3, 32'h80FF7F01, 32'h0);
        chk("lb_off3_lit", {32'h0, bus.o_rf_write_data}, {32'h0, 32'hFFFFFF80});
        step("lbu_off1", 2'd1, 5'd2, 1'b1, 1'b1, 3'b100, 2'd1, 32'h80FF7F01, 32'h0);
        chk("lbu_off1_lit", {32'h0, bus.o_rf_write_data}, {32'h0, 32'h0000007F});
        step("lh_off2", 2'd0, 5'd3, 1'b1, 1'b1, 3'b001, 2'd2, 32'h80FF7F01, 32'h0);
        chk("lh_off2_lit", {32'h0, bus.o_rf_write_data}, {32'h0, 32'hFFFF80FF});
        step("lhu_off0", 2'd0, 5'd4, 1'b1, 1'b1, 3'b101, 2'd0, 32'h80FF7F01, 32'h0);
        chk("lhu_off0_lit", {32'h0, bus.o_rf_write_data}, {32'h0, 32'h00007F01});
        step("lh_off3", 2'd2, 5'd6, 1'b1, 1'b1, 3'b001, 2'd3, 32'h80FF7F01, 32'h0);
        step("lw_off1", 2'd3, 5'd8, 1'b1, 1'b1, 3'b010, 2'd1, 32'h80FF7F01, 32'h0);
        chk("lw_lit", {32'h0, bus.o_rf_write_data}, {32'h0, 32'h80FF7F01});

        step("bad_f3_x0", 2'd1, 5'd0, 1'b1, 1'b1, 3'b011, 2'd0, 32'h1, 32'h0);
        step("bad_f3_noen", 2'd1, 5'd7, 1'b0, 1'b1, 3'b110, 2'd0, 32'h1, 32'h0);
        step("bad_f3_rd7", 2'd1, 5'd7, 1'b1, 1'b1, 3'b011, 2'd0, 32'h1, 32'h0);
        chk("fmt_err_set", {63'h0, bus.o_fmt_err}, 64'h1);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("idle%0d", i), 2'd0, 5'd0, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0, 32'h0);
        end
        chk("fmt_err_sticky", {63'h0, bus.o_fmt_err}, 64'h1);

        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
        end
        step("b2b_a", 2'd1, 5'd10, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'hA5A5A5A5);
        step("b2b_b", 2'd2, 5'd11, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h5A5A5A5A);
        step("b2b_c", 2'd3, 5'd12, 1'b1, 1'b1, 3'b000, 2'd0, 32'h000000FF, 32'h0);

        do_reset("reset_b");
        sweep(128, 40);
        chk("drop_err_set", {63'h0, bus.o_drop_err}, 64'h1);
        step("post_drop", 2'd0, 5'd1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 32'h77);

        do_reset("reset_c");
        sweep(60, 0);
        do_reset("reset_mid");
        sweep(128, 0);
        chk("drop_cleared", {63'h0, bus.o_drop_err}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_stage.md
Name: regfile_wb_stage

Overview:
- Writeback stage sitting directly upstream of the write port of the barrel-threaded register file.
- Formats load data (LB/LH/LW/LBU/LHU) or passes the ALU result, and suppresses writes to x0.
- Presents a registered write request (thread index, rd, data, enable) to the register file.
- After reset, a sweep FSM zero-fills all NUM_THREADS*32 entries, because block RAM has no reset. The core waits on o_init_done before issuing instructions.

Parameters:
- NUM_THREADS, 16: number of hardware threads (power of 2, ≥2). TW = $clog2(NUM_THREADS).
- DWIDTH, 32: register width. Fixed at 32 for the load formatter.
- CLEAR_ON_RESET, 1: 1 = run the zero-fill sweep after reset; 0 = enter RUN directly.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: synchronous, active-low reset.
- i_thread_index, in, TW: thread owning the instruction in writeback.
- i_rd_addr, in, 5: destination register.
- i_wb_en, in, 1: instruction writes rd.
- i_is_load, in, 1: select formatted memory data instead of i_alu_result.
- i_load_funct3, in, 3: load type.
- i_byte_offset, in, 2: load address bits [1:0].
- i_mem_rdata, in, 32: raw data word from data memory.
- i_alu_result, in, 32: non-load result.
- o_rf_thread_index, out, TW: register-file write thread index.
- o_rf_write_addr, out, 5: register-file write address.
- o_rf_write_data, out, 32: register-file write data.
- o_rf_wr_en, out, 1: register-file write enable.
- o_init_done, out, 1: sweep complete, core may issue.
- o_drop_err, out, 1: sticky; a writeback arrived during the sweep.
- o_fmt_err, out, 1: sticky; a load had an illegal funct3.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All outputs go to 0 and the sweep counter CNT (TW+5 bits) goes to 0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN. In the RUN case, o_init_done=1 from the first cycle after reset.
  - Reset asserted mid-sweep restarts the sweep at entry 0.
- State CLEAR:
  - Each cycle registers a write with o_rf_wr_en=1, o_rf_thread_index=CNT[TW+4:5], o_rf_write_addr=CNT[4:0], o_rf_write_data=0. Then CNT increments.
  - Clear writes appear on the outputs on cycles 1..RF_SIZE after reset release, where RF_SIZE = NUM_THREADS*32. Every entry is written exactly once, in ascending order, including x0.
  - When CNT = RF_SIZE-1 is issued, the next state is RUN.
  - o_init_done rises on cycle RF_SIZE+1 and stays 1 until reset.
  - Any i_wb_en=1 during CLEAR is ignored and sets o_drop_err.
- State RUN: one-cycle registered latency. A write is issued when i_wb_en=1, i_rd_addr≠0, and the load format is legal.
  - On issue, the next cycle has o_rf_wr_en=1 with the captured thread, rd and data.
  - When no write is issued, o_rf_wr_en=0 and the thread/addr/data registers hold their previous values.
  - Back-to-back writes every cycle are supported, with no bubbles.
- Load formatting (i_is_load=1):
  - 000 LB: byte at i_byte_offset, sign-extended.
  - 100 LBU: byte at i_byte_offset, zero-extended.
  - 001 LH: halfword selected by i_byte_offset[1], sign-extended.
  - 101 LHU: halfword selected by i_byte_offset[1], zero-extended.
  - For LH/LHU, i_byte_offset[0] is ignored.
  - 010 LW: i_mem_rdata unchanged; offset ignored.
  - 011/110/111: write suppressed and o_fmt_err set (sticky until reset). This happens even if rd=0 or i_wb_en=0? No: o_fmt_err is set only when i_wb_en=1 and i_is_load=1.
- Non-load (i_is_load=0): data = i_alu_result, and funct3 is ignored.
- x0: rd=0 never produces a write in RUN and never raises an error.
- Sticky errors clear only on reset.

Test Plan:
- Reset with NUM_THREADS=4, CLEAR_ON_RESET=1, release at cycle 0:
  - o_rf_wr_en=1 on cycles 1..128 with addresses (0,0),(0,1)…(3,31) and data 0.
  - o_init_done=1 on cycle 129.
- ALU writes in RUN, thread 2 rd=5 0xDEADBEEF followed by thread 3 rd=0 0x1234:
  - Next cycle: wr_en=1, (2,5), 0xDEADBEEF.
  - The cycle after: wr_en=0 and the outputs still hold (2,5,0xDEADBEEF).
- Loads with i_mem_rdata=0x80FF7F01:
  - LB off=3 → 0xFFFFFF80; LBU off=1 → 0x0000007F.
  - LH off=2 → 0xFFFF80FF; LHU off=0 → 0x00007F01; LW → 0x80FF7F01.
- Illegal funct3=011 with rd=7, i_wb_en=1, is_load=1: no write, o_fmt_err=1, still set after 10 idle cycles.
- Writeback pulse at sweep cycle 40: o_drop_err=1, and the sweep sequence is unchanged.
- reset_n low for 1 cycle at sweep cycle 60: outputs go to 0, then the sweep restarts at entry (0,0) and completes with the full 128 writes.
